// File: rtl/wb_arbiter2_if.sv
// Wishbone B3 classic bus bundle used on every arbiter port.
// The master modport is the side that issues cycles (CPU, loader, or the
// arbiter facing the slave); the slave modport is the side that answers them.
interface wb_arbiter2_if #(
  parameter int AW = 32,
  parameter int DW = 32
);

  logic [AW-1:0]   adr;
  logic [DW-1:0]   dat_w;
  logic [DW-1:0]   dat_r;
  logic [DW/8-1:0] sel;
  logic            we;
  logic            cyc;
  logic            stb;
  logic            ack;
  logic            err;

  modport master (
    output adr, dat_w, sel, we, cyc, stb,
    input  dat_r, ack, err
  );

  modport slave (
    input  adr, dat_w, sel, we, cyc, stb,
    output dat_r, ack, err
  );

endinterface

// File: rtl/wb_arbiter2.sv
// Two-master, one-slave Wishbone B3 classic arbiter.
// Master 0 is the CPU, master 1 a secondary requester (debug/DMA loader).
// Ownership is granted round-robin and held for a whole cyc; every hand-over
// passes through IDLE, which gives the slave one cycle with cyc=stb=0 so its
// registered ack clears before the next owner starts. A per-transfer watchdog
// turns a hung slave into a one-cycle err pulse to the current owner.
module wb_arbiter2 #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic         wb_clk_i,
  input  logic         wb_rst_i,
  wb_arbiter2_if.slave  m0,
  wb_arbiter2_if.slave  m1,
  wb_arbiter2_if.master s,
  output logic [1:0]   grant_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_nextState;
  // Owner of the most recently finished cyc; a tie goes to the other master.
  logic            r_last;

  logic [AW-1:0]   w_adr;
  logic [DW-1:0]   w_datW;
  logic [DW/8-1:0] w_sel;
  logic            w_we;
  logic            w_cyc;
  logic            w_ownStb;
  logic            w_sStb;
  logic            w_errPulse;

  // State register and round-robin memory; last is updated as an owner leaves.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state <= IDLE;
      r_last  <= 1'b1;
    end else begin
      r_state <= w_nextState;
      if (r_state == OWN0 && !m0.cyc) begin
        r_last <= 1'b0;
      end
      if (r_state == OWN1 && !m1.cyc) begin
        r_last <= 1'b1;
      end
    end
  end

  // Next-state logic: grant only from IDLE, keep the owner until it drops cyc.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: begin
        if (m0.cyc && !m1.cyc) begin
          w_nextState = OWN0;
        end else if (!m0.cyc && m1.cyc) begin
          w_nextState = OWN1;
        end else if (m0.cyc && m1.cyc) begin
          w_nextState = r_last ? OWN0 : OWN1;
        end
      end
      OWN0: begin
        if (!m0.cyc) begin
          w_nextState = IDLE;
        end
      end
      OWN1: begin
        if (!m1.cyc) begin
          w_nextState = IDLE;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Slave-side mux driven purely from the registered owner; IDLE parks the bus at 0.
  always_comb begin
    w_adr    = '0;
    w_datW   = '0;
    w_sel    = '0;
    w_we     = 1'b0;
    w_cyc    = 1'b0;
    w_ownStb = 1'b0;
    case (r_state)
      OWN0: begin
        w_adr    = m0.adr;
        w_datW   = m0.dat_w;
        w_sel    = m0.sel;
        w_we     = m0.we;
        w_cyc    = m0.cyc;
        w_ownStb = m0.stb;
      end
      OWN1: begin
        w_adr    = m1.adr;
        w_datW   = m1.dat_w;
        w_sel    = m1.sel;
        w_we     = m1.we;
        w_cyc    = m1.cyc;
        w_ownStb = m1.stb;
      end
      default: begin
        w_adr    = '0;
        w_datW   = '0;
        w_sel    = '0;
        w_we     = 1'b0;
        w_cyc    = 1'b0;
        w_ownStb = 1'b0;
      end
    endcase
    // The strobe is withdrawn during the err cycle so the abandoned transfer
    // cannot complete late at the slave.
    w_sStb = w_ownStb & ~w_errPulse;
  end

  assign s.adr   = w_adr;
  assign s.dat_w = w_datW;
  assign s.sel   = w_sel;
  assign s.we    = w_we;
  assign s.cyc   = w_cyc;
  assign s.stb   = w_sStb;

  // Read data is broadcast unqualified; masters only trust it alongside ack.
  assign m0.dat_r = s.dat_r;
  assign m1.dat_r = s.dat_r;

  // An err pulse suppresses any ack in the same cycle, and only the owner sees either.
  assign m0.ack = s.ack & (r_state == OWN0) & ~w_errPulse;
  assign m1.ack = s.ack & (r_state == OWN1) & ~w_errPulse;
  assign m0.err = w_errPulse & (r_state == OWN0);
  assign m1.err = w_errPulse & (r_state == OWN1);

  assign grant_o = {r_state == OWN1, r_state == OWN0};

  generate
    if (TIMEOUT > 0) begin : g_wdog
      localparam int WDW = $clog2(TIMEOUT + 1);
      localparam logic [WDW-1:0] LIMIT = WDW'(TIMEOUT - 1);
      localparam logic [WDW-1:0] SATMAX = WDW'(TIMEOUT);

      logic [WDW-1:0] r_wdog;
      logic           r_errPulse;
      logic           w_fire;

      // Timeout fires on the last allowed cycle of an unacked strobe; an ack
      // arriving on that very cycle takes priority.
      assign w_fire = w_sStb & ~s.ack & (r_wdog == LIMIT);

      // Per-transfer ack watchdog: counts strobe cycles, restarts on every ack.
      always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
          r_wdog     <= '0;
          r_errPulse <= 1'b0;
        end else begin
          r_errPulse <= w_fire;
          if (r_state == IDLE || !w_sStb || s.ack || w_fire) begin
            r_wdog <= '0;
          end else if (r_wdog != SATMAX) begin
            r_wdog <= r_wdog + 1'b1;
          end
        end
      end

      assign w_errPulse = r_errPulse;
    end else begin : g_noWdog
      assign w_errPulse = 1'b0;
    end
  endgenerate

endmodule

// File: tb/tb_wb_arbiter2.sv
// Directed testbench for wb_arbiter2 with a small registered-ack slave model.
module tb_wb_arbiter2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] grant;

  int vectors     = 0;
  int miscompares = 0;

  wb_arbiter2_if #(.AW(32), .DW(32)) m0If ();
  wb_arbiter2_if #(.AW(32), .DW(32)) m1If ();
  wb_arbiter2_if #(.AW(32), .DW(32)) sIf ();

  wb_arbiter2 #(.AW(32), .DW(32), .TIMEOUT(8)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .m0       (m0If),
    .m1       (m1If),
    .s        (sIf),
    .grant_o  (grant)
  );

  always #5 clk = ~clk;

  // Slave model: acks one cycle after seeing stb, logs writes, read data from address.
  logic        slaveOn  = 1'b1;
  logic        forceAck = 1'b0;
  logic        sAckReg  = 1'b0;
  logic [31:0] wrAdr [0:63];
  logic [31:0] wrDat [0:63];
  int          wrCount = 0;

  always @(posedge clk) begin
    if (sIf.cyc && sIf.stb && !sAckReg && slaveOn) begin
      sAckReg <= 1'b1;
      if (sIf.we && wrCount < 64) begin
        wrAdr[wrCount] <= sIf.adr;
        wrDat[wrCount] <= sIf.dat_w;
        wrCount        <= wrCount + 1;
      end
    end else begin
      sAckReg <= 1'b0;
    end
  end

  assign sIf.ack   = sAckReg | forceAck;
  assign sIf.dat_r = (sIf.adr == 32'h0000_0010) ? 32'h1234_5678 : ~sIf.adr;
  assign sIf.err   = 1'b0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clearMasters();
    m0If.adr = '0; m0If.dat_w = '0; m0If.sel = '0; m0If.we = 1'b0; m0If.cyc = 1'b0; m0If.stb = 1'b0;
    m1If.adr = '0; m1If.dat_w = '0; m1If.sel = '0; m1If.we = 1'b0; m1If.cyc = 1'b0; m1If.stb = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    m0If.cyc = 1'b1; m0If.stb = 1'b1;
    m1If.cyc = 1'b1; m1If.stb = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++;
      if (grant !== 2'b00) begin
        miscompares++; $display("[TB] FAIL reset_grant cyc%0d: got %b expected 00", i, grant);
      end
      vectors++;
      if (sIf.cyc !== 1'b0 || m0If.ack !== 1'b0 || m1If.err !== 1'b0) begin
        miscompares++; $display("[TB] FAIL reset_bus cyc%0d: got cyc=%b ack0=%b err1=%b expected 0,0,0", i, sIf.cyc, m0If.ack, m1If.err);
      end
    end
    clearMasters();
    rst = 1'b0;
    step();
  endtask

  task automatic test_tie();
    m0If.cyc = 1'b1; m0If.stb = 1'b1; m0If.adr = 32'h20;
    m1If.cyc = 1'b1; m1If.stb = 1'b1; m1If.adr = 32'h40;
    step();
    vectors++;
    if (grant !== 2'b01 || sIf.adr !== 32'h20) begin
      miscompares++; $display("[TB] FAIL tie_first: got grant=%b adr=%h expected 01 00000020", grant, sIf.adr);
    end
    step();
    vectors++;
    if (m0If.ack !== 1'b1 || m1If.ack !== 1'b0 || m0If.dat_r !== 32'hFFFF_FFDF) begin
      miscompares++; $display("[TB] FAIL tie_ack0: got ack0=%b ack1=%b dat=%h expected 1 0 ffffffdf", m0If.ack, m1If.ack, m0If.dat_r);
    end
    m0If.cyc = 1'b0; m0If.stb = 1'b0;
    step();
    vectors++;
    if (grant !== 2'b00 || sIf.cyc !== 1'b0) begin
      miscompares++; $display("[TB] FAIL tie_dead: got grant=%b cyc=%b expected 00 0", grant, sIf.cyc);
    end
    step();
    vectors++;
    if (grant !== 2'b10 || sIf.adr !== 32'h40) begin
      miscompares++; $display("[TB] FAIL tie_second: got grant=%b adr=%h expected 10 00000040", grant, sIf.adr);
    end
    step();
    vectors++;
    if (m1If.ack !== 1'b1 || m0If.ack !== 1'b0) begin
      miscompares++; $display("[TB] FAIL tie_ack1: got ack1=%b ack0=%b expected 1 0", m1If.ack, m0If.ack);
    end
    m1If.cyc = 1'b0; m1If.stb = 1'b0;
    step();
    m0If.cyc = 1'b1; m0If.stb = 1'b1;
    m1If.cyc = 1'b1; m1If.stb = 1'b1;
    step();
    vectors++;
    if (grant !== 2'b01) begin
      miscompares++; $display("[TB] FAIL tie_alt_m0: got %b expected 01", grant);
    end
    clearMasters();
    step();
    m0If.cyc = 1'b1; m0If.stb = 1'b1;
    m1If.cyc = 1'b1; m1If.stb = 1'b1; m1If.adr = 32'h40;
    step();
    vectors++;
    if (grant !== 2'b10) begin
      miscompares++; $display("[TB] FAIL tie_alt_m1: got %b expected 10", grant);
    end
    clearMasters();
    step();
    step();
  endtask

  task automatic test_single();
    m0If.cyc = 1'b1; m0If.stb = 1'b1; m0If.we = 1'b0; m0If.adr = 32'h0000_0010; m0If.sel = 4'hF;
    vectors++;
    if (grant !== 2'b00) begin
      miscompares++; $display("[TB] FAIL single_pre: got %b expected 00", grant);
    end
    step();
    vectors++;
    if (grant !== 2'b01 || m0If.ack !== 1'b0) begin
      miscompares++; $display("[TB] FAIL single_grant: got grant=%b ack=%b expected 01 0", grant, m0If.ack);
    end
    step();
    vectors++;
    if (m0If.ack !== 1'b1 || m0If.dat_r !== 32'h1234_5678 || m1If.ack !== 1'b0) begin
      miscompares++; $display("[TB] FAIL single_ack: got ack0=%b dat=%h ack1=%b expected 1 12345678 0", m0If.ack, m0If.dat_r, m1If.ack);
    end
    clearMasters();
    step();
    vectors++;
    if (m0If.ack !== 1'b0 || grant !== 2'b00) begin
      miscompares++; $display("[TB] FAIL single_end: got ack=%b grant=%b expected 0 00", m0If.ack, grant);
    end
    step();
  endtask

  task automatic test_back_to_back();
    int base;
    int budget;
    base = wrCount;
    m0If.cyc = 1'b1; m0If.stb = 1'b1; m0If.we = 1'b1; m0If.sel = 4'hF;
    m0If.adr = 32'h100; m0If.dat_w = 32'hA000_0000;
    step();
    vectors++;
    if (grant !== 2'b01) begin
      miscompares++; $display("[TB] FAIL b2b_grant: got %b expected 01", grant);
    end
    m1If.cyc = 1'b1; m1If.stb = 1'b1; m1If.adr = 32'h300;
    for (int k = 0; k < 4; k++) begin
      m0If.adr   = 32'h100 + 32'(4 * k);
      m0If.dat_w = 32'hA000_0000 + 32'(k);
      budget = 0;
      do begin
        step();
        budget++;
        vectors++;
        if (grant !== 2'b01) begin
          miscompares++; $display("[TB] FAIL b2b_hold w%0d: got %b expected 01", k, grant);
        end
      end while (m0If.ack !== 1'b1 && budget < 8);
      if (m0If.ack !== 1'b1) begin
        miscompares++; $display("[TB] FAIL b2b_ack_timeout w%0d: got ack=%b expected 1", k, m0If.ack);
      end
    end
    m0If.cyc = 1'b0; m0If.stb = 1'b0; m0If.we = 1'b0;
    step();
    vectors++;
    if (grant !== 2'b00 || sIf.cyc !== 1'b0) begin
      miscompares++; $display("[TB] FAIL b2b_dead: got grant=%b cyc=%b expected 00 0", grant, sIf.cyc);
    end
    step();
    vectors++;
    if (grant !== 2'b10) begin
      miscompares++; $display("[TB] FAIL b2b_m1: got %b expected 10", grant);
    end
    vectors++;
    if (wrCount - base !== 4) begin
      miscompares++; $display("[TB] FAIL b2b_count: got %0d writes expected 4", wrCount - base);
    end else begin
      for (int k = 0; k < 4; k++) begin
        vectors++;
        if (wrAdr[base + k] !== 32'h100 + 32'(4 * k) || wrDat[base + k] !== 32'hA000_0000 + 32'(k)) begin
          miscompares++; $display("[TB] FAIL b2b_data w%0d: got %h/%h expected %h/%h", k, wrAdr[base + k], wrDat[base + k], 32'h100 + 32'(4 * k), 32'hA000_0000 + 32'(k));
        end
      end
    end
    clearMasters();
    step();
    step();
  endtask

  task automatic test_watchdog();
    slaveOn = 1'b0;
    m1If.cyc = 1'b1; m1If.stb = 1'b1; m1If.adr = 32'h200;
    step();
    vectors++;
    if (sIf.stb !== 1'b1 || m1If.err !== 1'b0) begin
      miscompares++; $display("[TB] FAIL wd_start: got stb=%b err=%b expected 1 0", sIf.stb, m1If.err);
    end
    for (int i = 1; i < 8; i++) begin
      step();
      vectors++;
      if (m1If.err !== 1'b0 || sIf.stb !== 1'b1) begin
        miscompares++; $display("[TB] FAIL wd_wait c%0d: got err=%b stb=%b expected 0 1", i, m1If.err, sIf.stb);
      end
    end
    step();
    vectors++;
    if (m1If.err !== 1'b1 || sIf.stb !== 1'b0 || m0If.err !== 1'b0 || m1If.ack !== 1'b0) begin
      miscompares++; $display("[TB] FAIL wd_fire: got err1=%b stb=%b err0=%b ack1=%b expected 1 0 0 0", m1If.err, sIf.stb, m0If.err, m1If.ack);
    end
    step();
    vectors++;
    if (m1If.err !== 1'b0 || grant !== 2'b10 || sIf.stb !== 1'b1) begin
      miscompares++; $display("[TB] FAIL wd_after: got err=%b grant=%b stb=%b expected 0 10 1", m1If.err, grant, sIf.stb);
    end
    clearMasters();
    step();
    step();
    m1If.cyc = 1'b1; m1If.stb = 1'b1; m1If.adr = 32'h204;
    for (int i = 0; i < 8; i++) begin
      step();
    end
    forceAck = 1'b1;
    #1;
    vectors++;
    if (m1If.ack !== 1'b1 || m1If.err !== 1'b0) begin
      miscompares++; $display("[TB] FAIL wd_ack_last: got ack=%b err=%b expected 1 0", m1If.ack, m1If.err);
    end
    step();
    forceAck = 1'b0;
    vectors++;
    if (m1If.err !== 1'b0) begin
      miscompares++; $display("[TB] FAIL wd_ack_wins: got err=%b expected 0", m1If.err);
    end
    step();
    vectors++;
    if (m1If.err !== 1'b0) begin
      miscompares++; $display("[TB] FAIL wd_ack_wins2: got err=%b expected 0", m1If.err);
    end
    clearMasters();
    step();
    step();
    slaveOn = 1'b1;
  endtask

  task automatic test_reset_mid();
    m1If.cyc = 1'b1; m1If.stb = 1'b1; m1If.adr = 32'h280;
    step();
    vectors++;
    if (grant !== 2'b10) begin
      miscompares++; $display("[TB] FAIL mid_grant: got %b expected 10", grant);
    end
    forceAck = 1'b1;
    rst = 1'b1;
    step();
    vectors++;
    if (grant !== 2'b00 || m1If.ack !== 1'b0 || sIf.cyc !== 1'b0) begin
      miscompares++; $display("[TB] FAIL mid_reset: got grant=%b ack1=%b cyc=%b expected 00 0 0", grant, m1If.ack, sIf.cyc);
    end
    forceAck = 1'b0;
    clearMasters();
    rst = 1'b0;
    step();
    step();
  endtask

  // Safety net so a stuck run still terminates with a visible failure.
  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got no finish expected finish");
    $fatal(1, "[TB] global timeout");
  end

  // Scenario sequence; each task leaves both masters idle and the arbiter in IDLE.
  initial begin
    clearMasters();
    test_reset();
    test_tie();
    test_single();
    test_back_to_back();
    test_watchdog();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
